pb_debounce: RTL and testbench

Push-button conditioning stage between the board's active-low PB pins and the NIOS switch PIO. It runs on the 50 MHz NIOS clock and synchronises each button. It debounces each button into a clean active-high level and emits single-cycle press, release and long-press pulses. It also holds a per-button sticky event flag that software acknowledges.

---
 rtl/pb_debounce_if.sv | 34 +++
 rtl/pb_debounce.sv | 99 +++++++++
 tb/tb_pb_debounce.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pb_debounce_if.sv
// rtl/pb_debounce_if.sv - button pins, event clear and conditioned button outputs
interface pb_debounce_if #(
    parameter int N = 3
);
    logic [N-1:0] pb_n;
    logic [N-1:0] evt_clr;
    logic [N-1:0] pb_level;
    logic [N-1:0] pb_press;
    logic [N-1:0] pb_release;
    logic [N-1:0] pb_long;
    logic [N-1:0] pb_evt;

    // Board/software side: drives pins and clears, observes conditioned buttons.
    modport master (
        output pb_n,
        output evt_clr,
        input  pb_level,
        input  pb_press,
        input  pb_release,
        input  pb_long,
        input  pb_evt
    );

    // Conditioning block side.
    modport slave (
        input  pb_n,
        input  evt_clr,
        output pb_level,
        output pb_press,
        output pb_release,
        output pb_long,
        output pb_evt
    );
endinterface

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - per-button synchroniser, debouncer, edge/long-press pulses and sticky event
module pb_debounce #(
    parameter int N               = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic          clk,
    input  logic          reset,
    pb_debounce_if.slave  bus
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [1:0]        sync_q;
            logic              raw;
            logic [CNT_W-1:0]  cnt_q;
            logic [HOLD_W-1:0] hold_q;
            logic              level_q;
            logic              press_q;
            logic              release_q;
            logic              long_q;
            logic              evt_q;

            // Pins are active-low; after synchronising, invert to pressed = 1.
            assign raw = ~sync_q[1];

            // Two-flop synchroniser; idles at released (1) so reset never looks like a press.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= 2'b11;
                end else begin
                    sync_q <= {sync_q[0], bus.pb_n[gi]};
                end
            end

            // Debounce: any cycle of agreement restarts the count; level and edge pulses update together.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    if (raw == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        level_q   <= raw;
                        press_q   <= raw;
                        release_q <= ~raw;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            // Hold counter saturates, so the long-press pulse can fire only once per press.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    long_q <= level_q && (hold_q == HOLD_PRE);
                    if (!level_q) begin
                        hold_q <= '0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
            end

            // Sticky event flag; a press in the same cycle as a clear keeps the flag set.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    evt_q <= 1'b0;
                end else if (press_q) begin
                    evt_q <= 1'b1;
                end else if (bus.evt_clr[gi]) begin
                    evt_q <= 1'b0;
                end
            end

            assign bus.pb_level[gi]   = level_q;
            assign bus.pb_press[gi]   = press_q;
            assign bus.pb_release[gi] = release_q;
            assign bus.pb_long[gi]    = long_q;
            assign bus.pb_evt[gi]     = evt_q;
        end
    endgenerate
endmodule

// File: tb/tb_pb_debounce.sv
// tb/tb_pb_debounce.sv - directed scoreboard bench for pb_debounce
module tb_pb_debounce;
    localparam int N = 3;
    localparam int D = 4;
    localparam int L = 10;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic clk;
    logic reset;

    pb_debounce_if #(.N(N)) bus ();

    pb_debounce #(
        .N(N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev_t          sbq[$];
    int           cyc;
    int           total;
    int           bad;
    string        step;
    logic [N-1:0] exp_level;
    logic [N-1:0] exp_press;
    logic [N-1:0] exp_rel;
    logic [N-1:0] exp_long;
    logic [N-1:0] exp_evt;

    task automatic check_all();
        total++;
        assert (bus.pb_level === exp_level) else begin
            bad++;
            $error("FAIL %s level cyc=%0d obs=%b exp=%b", step, cyc, bus.pb_level, exp_level);
        end
        total++;
        assert (bus.pb_press === exp_press) else begin
            bad++;
            $error("FAIL %s press cyc=%0d obs=%b exp=%b", step, cyc, bus.pb_press, exp_press);
        end
        total++;
        assert (bus.pb_release === exp_rel) else begin
            bad++;
            $error("FAIL %s release cyc=%0d obs=%b exp=%b", step, cyc, bus.pb_release, exp_rel);
        end
        total++;
        assert (bus.pb_long === exp_long) else begin
            bad++;
            $error("FAIL %s long cyc=%0d obs=%b exp=%b", step, cyc, bus.pb_long, exp_long);
        end
        total++;
        assert (bus.pb_evt === exp_evt) else begin
            bad++;
            $error("FAIL %s evt cyc=%0d obs=%b exp=%b", step, cyc, bus.pb_evt, exp_evt);
        end
    endtask

    // One clock: update the expectation from the scoreboard, then compare at the falling edge.
    task automatic tick();
        logic [N-1:0] clr_s;
        clr_s = bus.evt_clr;
        @(posedge clk);
        cyc++;
        if (reset) begin
            exp_evt = '0;
        end else begin
            exp_evt = exp_press | (exp_evt & ~clr_s);
        end
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                case (sbq[i].kind)
                    K_PRESS: exp_press[sbq[i].ch] = 1'b1;
                    K_REL:   exp_rel[sbq[i].ch]   = 1'b1;
                    default: exp_long[sbq[i].ch]  = 1'b1;
                endcase
                sbq.delete(i);
            end
        end
        exp_level = (exp_level | exp_press) & ~exp_rel;
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pin goes low now; first sampled at edge cyc+1, accepted D+1 edges later.
    task automatic press(input int ch);
        int p;
        bus.pb_n[ch] = 1'b0;
        p = cyc + D + 2;
        sbq.push_back('{cyc: p, ch: ch, kind: K_PRESS});
        sbq.push_back('{cyc: p + L, ch: ch, kind: K_LONG});
    endtask

    // Pin returns high; a long pulse due after the level drops can no longer fire.
    task automatic release_pb(input int ch);
        int r;
        bus.pb_n[ch] = 1'b1;
        r = cyc + D + 2;
        sbq.push_back('{cyc: r, ch: ch, kind: K_REL});
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].ch == ch && sbq[i].kind == K_LONG && sbq[i].cyc > r) sbq.delete(i);
        end
    endtask

    initial begin
        cyc       = 0;
        total     = 0;
        bad       = 0;
        exp_level = '0;
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
        exp_evt   = '0;

        step        = "reset";
        reset       = 1'b1;
        bus.pb_n    = 3'b000;
        bus.evt_clr = 3'b000;
        #1;
        check_all();
        ticks(3);
        reset    = 1'b0;
        bus.pb_n = 3'b111;
        step     = "idle";
        ticks(20);

        step = "clean_press";
        press(0);
        ticks(8);
        release_pb(0);
        ticks(10);

        step = "bounce";
        bus.pb_n[1] = 1'b0;
        ticks(3);
        bus.pb_n[1] = 1'b1;
        ticks(1);
        bus.pb_n[1] = 1'b0;
        ticks(3);
        bus.pb_n[1] = 1'b1;
        ticks(1);
        press(1);
        ticks(8);
        release_pb(1);
        ticks(10);

        step = "long_press";
        press(2);
        ticks(30);
        release_pb(2);
        ticks(10);
        step = "short_press";
        press(2);
        ticks(5);
        release_pb(2);
        ticks(10);

        step = "clear";
        bus.evt_clr = 3'b001;
        tick();
        bus.evt_clr = 3'b000;
        tick();
        bus.evt_clr = 3'b100;
        tick();
        bus.evt_clr = 3'b000;
        tick();
        step = "clear_collision";
        press(0);
        ticks(6);
        bus.evt_clr[0] = 1'b1;
        tick();
        bus.evt_clr[0] = 1'b0;
        ticks(2);
        step = "clear_lone";
        bus.evt_clr[0] = 1'b1;
        tick();
        bus.evt_clr[0] = 1'b0;
        ticks(2);
        release_pb(0);
        ticks(10);

        step = "mid_reset";
        press(0);
        ticks(7);
        bus.pb_n[1] = 1'b0;
        ticks(4);
        reset = 1'b1;
        #1;
        sbq.delete();
        exp_level = '0;
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
        exp_evt   = '0;
        check_all();
        tick();
        reset = 1'b0;
        step  = "after_reset";
        press(0);
        press(1);
        ticks(20);
        release_pb(0);
        release_pb(1);
        ticks(10);

        total++;
        assert (sbq.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain obs=%0d exp=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
